pc_fetch_stage: RTL and testbench

//  Fetch-side state of the 5-stage MIPS pipeline: the PC register plus the IF/ID pipeline register.

---
 rtl/pc_fetch_stage.sv | 137 +++++++++++++
 tb/tb_pc_fetch_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
//   Fetch side of the 5-stage MIPS pipeline: the PC register and the IF/ID
//   pipeline register. The PC is checked for a legal fetch address every
//   cycle. An illegal fetch is turned into a nop that carries an AdEL code
//   down the pipe, so CP0 can raise the exception later.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   next_pc    in   32  next fetch address from npc (already vector when Interrupt)
//   instr_in   in   32  IM read data for address PC (combinational)
//   stall      in   1   hold PC and IF/ID
//   Interrupt  in   1   CP0 redirect; overrides stall and eret_D
//   eret_D     in   1   eret in D: redirect to EPC and flush IF/ID
//   branch_D   in   1   branch/jump in D; current fetch is its delay slot
//   PC         out  32  current fetch address
//   PC4        out  32  PC + 4 (combinational, wraps modulo 2^32)
//   InstrD     out  32  IF/ID instruction
//   PCD        out  32  IF/ID PC
//   PC4D       out  32  IF/ID PC + 4
//   ExcCodeD   out  5   IF/ID fetch exception code, 0 = none
//   BDD        out  1   IF/ID branch-delay-slot flag
//   ValidD     out  1   IF/ID holds a real fetch rather than a bubble
// -----------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        Interrupt,
    input  logic        eret_D,
    input  logic        branch_D,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PC4D,
    output logic [4:0]  ExcCodeD,
    output logic        BDD,
    output logic        ValidD
);

    // PC register and IF/ID fields
    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc4_d;
    logic [4:0]  r_exc_d;
    logic        r_bd_d;
    logic        r_valid_d;

    // Fetch-address check
    logic        w_misaligned;
    logic        w_below;
    logic        w_above;
    logic        w_fault;
    logic [31:0] w_pc4;
    logic [31:0] w_instr_f;
    logic [4:0]  w_exc_f;

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_below      = (r_pc < IM_BASE);
    assign w_above      = (r_pc > IM_LIMIT);
    assign w_fault      = w_misaligned | w_below | w_above;

    // 32-bit add drops the carry, so 0xFFFF_FFFC + 4 wraps to 0.
    assign w_pc4        = r_pc + 32'd4;

    // A faulting fetch must not leak whatever IM returned; it becomes a nop
    // tagged with AdEL and still advances as a valid instruction.
    assign w_instr_f    = w_fault ? 32'h0000_0000 : instr_in;
    assign w_exc_f      = w_fault ? EXC_ADEL      : 5'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_instr_d <= 32'h0;
            r_pc_d    <= 32'h0;
            r_pc4_d   <= 32'h0;
            r_exc_d   <= 5'd0;
            r_bd_d    <= 1'b0;
            r_valid_d <= 1'b0;
        end else if (Interrupt) begin
            // Redirect to the handler; the in-flight fetch is squashed.
            r_pc      <= next_pc;
            r_instr_d <= 32'h0;
            r_pc_d    <= 32'h0;
            r_pc4_d   <= 32'h0;
            r_exc_d   <= 5'd0;
            r_bd_d    <= 1'b0;
            r_valid_d <= 1'b0;
        end else if (stall) begin
            // Hold everything; eret_D / branch_D are re-seen once the stall clears.
            r_pc      <= r_pc;
            r_instr_d <= r_instr_d;
            r_pc_d    <= r_pc_d;
            r_pc4_d   <= r_pc4_d;
            r_exc_d   <= r_exc_d;
            r_bd_d    <= r_bd_d;
            r_valid_d <= r_valid_d;
        end else if (eret_D) begin
            // eret has no delay slot: jump to EPC and drop the fetched word.
            r_pc      <= next_pc;
            r_instr_d <= 32'h0;
            r_pc_d    <= 32'h0;
            r_pc4_d   <= 32'h0;
            r_exc_d   <= 5'd0;
            r_bd_d    <= 1'b0;
            r_valid_d <= 1'b0;
        end else begin
            r_pc      <= next_pc;
            r_instr_d <= w_instr_f;
            r_pc_d    <= r_pc;
            r_pc4_d   <= w_pc4;
            r_exc_d   <= w_exc_f;
            r_bd_d    <= branch_D;
            r_valid_d <= 1'b1;
        end
    end

    assign PC       = r_pc;
    assign PC4      = w_pc4;
    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PC4D     = r_pc4_d;
    assign ExcCodeD = r_exc_d;
    assign BDD      = r_bd_d;
    assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_stage
//   Scoreboard bench: each driven cycle pushes the expected PC + IF/ID state,
//   which is popped and compared one time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc4d;
        logic [4:0]  exc;
        logic        bdd;
        logic        vld;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic [31:0] instr_in;
    logic        stall;
    logic        Interrupt;
    logic        eret_D;
    logic        branch_D;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PC4D;
    logic [4:0]  ExcCodeD;
    logic        BDD;
    logic        ValidD;

    obs_t        obs;
    obs_t        m;       // reference model state
    obs_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    pc_fetch_stage dut (
        .clk      (clk),
        .reset    (reset),
        .next_pc  (next_pc),
        .instr_in (instr_in),
        .stall    (stall),
        .Interrupt(Interrupt),
        .eret_D   (eret_D),
        .branch_D (branch_D),
        .PC       (PC),
        .PC4      (PC4),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PC4D     (PC4D),
        .ExcCodeD (ExcCodeD),
        .BDD      (BDD),
        .ValidD   (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] im(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
    endfunction

    assign instr_in = im(PC);
    assign obs      = {PC, InstrD, PCD, PC4D, ExcCodeD, BDD, ValidD};

    // Drive one cycle, push the predicted post-edge state, step past the edge.
    task automatic advance(input logic intr, input logic stl, input logic er,
                           input logic br, input logic [31:0] npc);
        logic f;
        Interrupt = intr; stall = stl; eret_D = er; branch_D = br; next_pc = npc;
        if (intr || (!stl && er)) begin
            m = '0;
            m.pc = npc;
        end else if (!stl) begin
            f       = fault(m.pc);
            m.instr = f ? 32'h0 : im(m.pc);
            m.pcd   = m.pc;
            m.pc4d  = m.pc + 32'd4;
            m.exc   = f ? 5'd4 : 5'd0;
            m.bdd   = br;
            m.vld   = 1'b1;
            m.pc    = npc;
        end
        sb_q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        obs_t exp, got;
        reset = 1'b1; stall = 0; Interrupt = 0; eret_D = 0; branch_D = 0; next_pc = 32'h0;
        m = '0; m.pc = 32'h0000_3000;
        #3;
        n_checks++;
        if (obs !== m) $display("FAIL reset_state: got %h expected %h", obs, m);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance(0, 0, 0, 0, m.pc + 32'd4);
            got = obs; exp = sb_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL reset_run%0d: got %h expected %h", i, got, exp);
            else n_pass++;
        end
        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (PC !== 32'h3000 || ValidD !== 1'b0)
            $display("FAIL reset_async: got PC=%h ValidD=%b expected PC=00003000 ValidD=0", PC, ValidD);
        else n_pass++;
        m = '0; m.pc = 32'h0000_3000;
        sb_q.delete();
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance(0, 0, 0, 0, m.pc + 32'd4);
            got = obs; exp = sb_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL reset_adv%0d: got %h expected %h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (PCD !== 32'h3008 || PC4D !== 32'h300C || PC !== 32'h300C)
            $display("FAIL reset_3edges: got PCD=%h PC4D=%h PC=%h expected 00003008 0000300c 0000300c",
                     PCD, PC4D, PC);
        else n_pass++;
    endtask

    task automatic test_stall;
        obs_t exp, got;
        logic [4:0]  stl_v [4] = '{0, 1, 1, 0};
        logic [31:0] npc_v [4] = '{32'h3010, 32'h3100, 32'h3200, 32'h3014};
        for (int i = 0; i < 4; i++) begin
            advance(0, stl_v[i][0], i == 1, i == 2, npc_v[i]);
            got = obs; exp = sb_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL stall_step%0d: got %h expected %h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (InstrD !== im(32'h3010) || PCD !== 32'h3010)
            $display("FAIL stall_release: got InstrD=%h PCD=%h expected %h 00003010",
                     InstrD, PCD, im(32'h3010));
        else n_pass++;
    endtask

    task automatic test_fault;
        obs_t exp, got;
        logic [31:0] npc_v [8] = '{32'h3002, 32'h3004, 32'h7000, 32'h6FFC,
                                   32'h2FFC, 32'h3000, 32'hFFFF_FFFC, 32'h3000};
        for (int i = 0; i < 8; i++) begin
            advance(0, 0, 0, 0, npc_v[i]);
            got = obs; exp = sb_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL fault_step%0d: got %h expected %h", i, got, exp);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (InstrD !== 32'h0 || ExcCodeD !== 5'd4 || PCD !== 32'h3002 || ValidD !== 1'b1)
                    $display("FAIL fault_misalign: got InstrD=%h Exc=%0d PCD=%h V=%b expected 0 4 00003002 1",
                             InstrD, ExcCodeD, PCD, ValidD);
                else n_pass++;
            end
            if (i == 3) begin
                n_checks++;
                if (ExcCodeD !== 5'd4 || PCD !== 32'h7000)
                    $display("FAIL fault_above: got Exc=%0d PCD=%h expected 4 00007000", ExcCodeD, PCD);
                else n_pass++;
            end
            if (i == 6) begin
                n_checks++;
                if (PC4 !== 32'h0)
                    $display("FAIL pc4_wrap: got %h expected 00000000", PC4);
                else n_pass++;
            end
        end
    endtask

    task automatic test_interrupt;
        obs_t exp, got;
        advance(0, 0, 0, 0, 32'h3020);
        got = obs; exp = sb_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL intr_pre: got %h expected %h", got, exp);
        else n_pass++;
        advance(1, 1, 1, 1, 32'h4180);
        got = obs; exp = sb_q.pop_front(); n_checks++;
        if (got !== exp) $display("FAIL intr_stall: got %h expected %h", got, exp);
        else n_pass++;
        n_checks++;
        if (PC !== 32'h4180 || ValidD !== 1'b0 || InstrD !== 32'h0)
            $display("FAIL intr_redirect: got PC=%h V=%b InstrD=%h expected 00004180 0 0", PC, ValidD, InstrD);
        else n_pass++;
    endtask

    task automatic test_eret;
        obs_t exp, got;
        logic        stl_v [4] = '{0, 0, 0, 1};
        logic        er_v  [4] = '{0, 1, 0, 1};
        logic [31:0] npc_v [4] = '{32'h3030, 32'h3040, 32'h3044, 32'h3080};
        for (int i = 0; i < 4; i++) begin
            advance(0, stl_v[i], er_v[i], 0, npc_v[i]);
            got = obs; exp = sb_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL eret_step%0d: got %h expected %h", i, got, exp);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (PC !== 32'h3040 || ValidD !== 1'b0 || PCD !== 32'h0)
                    $display("FAIL eret_flush: got PC=%h V=%b PCD=%h expected 00003040 0 0", PC, ValidD, PCD);
                else n_pass++;
            end
        end
        n_checks++;
        if (PC !== 32'h3044 || PCD !== 32'h3040 || ValidD !== 1'b1)
            $display("FAIL eret_stalled: got PC=%h PCD=%h V=%b expected 00003044 00003040 1", PC, PCD, ValidD);
        else n_pass++;
    endtask

    task automatic test_branch;
        obs_t exp, got;
        logic        er_v  [4] = '{0, 0, 0, 1};
        logic        br_v  [4] = '{0, 1, 0, 1};
        logic [31:0] npc_v [4] = '{32'h3024, 32'h3028, 32'h302C, 32'h3040};
        for (int i = 0; i < 4; i++) begin
            advance(0, 0, er_v[i], br_v[i], npc_v[i]);
            got = obs; exp = sb_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL branch_step%0d: got %h expected %h", i, got, exp);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (PCD !== 32'h3024 || BDD !== 1'b1)
                    $display("FAIL branch_bd: got PCD=%h BDD=%b expected 00003024 1", PCD, BDD);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if (BDD !== 1'b0)
                    $display("FAIL branch_clear: got BDD=%b expected 0", BDD);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_fault();
        test_interrupt();
        test_eret();
        test_branch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
